customer_dispense: RTL and testbench

Customer-side counterpart of `Owner_charge`. `Owner_charge` restocks the machine and reports the total on `supply_out`. This block consumes that stock. It accumulates coin credit, accepts a purchase request, pulses `dispense` once per item, decrements stock, and returns change. It sits between the coin/keypad front end and the owner restock path, and owns the live stock count and the `redLight` empty indicator.

---
 rtl/vending_pkg.sv | 14 +
 rtl/customer_dispense.sv | 132 +++++++++++++
 tb/tb_customer_dispense.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending datapath: FSM states and register widths.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam int STOCK_W    = 4;
    localparam int CREDIT_W   = 4;
    localparam int MAX_CREDIT = 15;

endpackage

// File: rtl/customer_dispense.sv
// Customer purchase path: accumulates coin credit, dispenses items one per cycle,
// decrements the shared stock count and returns change or a refund.
module customer_dispense
    import vending_pkg::*;
#(
    parameter int PRICE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [STOCK_W-1:0]  supply_in,
    input  logic                coin,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                req,
    input  logic [3:0]          qty,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change,
    output logic                err,
    output logic                busy,
    output logic                redLight,
    output logic [STOCK_W-1:0]  supply_out
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

    state_t                state_q, state_d;
    logic [STOCK_W-1:0]    stock_q, stock_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [3:0]            remain_q, remain_d;
    logic [CREDIT_W-1:0]   change_q, change_d;
    logic                  err_d;
    logic                  err_q, dispense_q, change_valid_q, busy_q;

    logic [CREDIT_W:0]     coin_sum;
    logic [7:0]            cost;

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
    assign cost     = 8'(qty) * 8'(PRICE);

    always_comb begin
        state_d  = state_q;
        stock_d  = stock_q;
        credit_d = credit_q;
        remain_d = remain_q;
        change_d = change_q;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    stock_d = supply_in;
                end
                if (coin) begin
                    if (coin_sum <= MAX_SUM) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Affordability uses the pre-coin credit; a concurrent coin still lands.
                if (cancel) begin
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                    end
                end else if (req && !load) begin
                    if (qty == 4'd0 || qty > stock_q || cost > 8'(credit_q)) begin
                        err_d = 1'b1;
                    end else begin
                        remain_d = qty;
                        state_d  = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                stock_d  = stock_q - 1'b1;
                credit_d = credit_q - PRICE_C;
                remain_d = remain_q - 1'b1;
                if (remain_q == 4'd1) begin
                    state_d = CHANGE;
                end
            end
            CHANGE: begin
                credit_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Latch the amount returned on entry to CHANGE so it is valid in the CHANGE cycle.
        if (state_d == CHANGE && state_q != CHANGE) begin
            change_d = credit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            stock_q        <= '0;
            credit_q       <= '0;
            remain_q       <= '0;
            change_q       <= '0;
            err_q          <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            stock_q        <= stock_d;
            credit_q       <= credit_d;
            remain_q       <= remain_d;
            change_q       <= change_d;
            err_q          <= err_d;
            dispense_q     <= (state_d == DISPENSE);
            change_valid_q <= (state_d == CHANGE);
            busy_q         <= (state_d != IDLE);
        end
    end

    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign supply_out   = stock_q;
    assign redLight     = (stock_q == '0);

endmodule

// File: tb/tb_customer_dispense.sv
// Directed scenarios plus randomized IDLE-cycle stimulus against a transaction-level
// model of stock and credit for customer_dispense.
module tb_customer_dispense;

    localparam int PRICE = 3;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] supply_in;
    logic       coin;
    logic [3:0] coin_value;
    logic       req;
    logic [3:0] qty;
    logic       cancel;
    logic       dispense;
    logic       change_valid;
    logic [3:0] change;
    logic       err;
    logic       busy;
    logic       redLight;
    logic [3:0] supply_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Transaction-level model: just the machine's stock and the customer's credit.
    int m_stock  = 0;
    int m_credit = 0;

    customer_dispense #(.PRICE(PRICE)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .supply_in    (supply_in),
        .coin         (coin),
        .coin_value   (coin_value),
        .req          (req),
        .qty          (qty),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change       (change),
        .err          (err),
        .busy         (busy),
        .redLight     (redLight),
        .supply_out   (supply_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load = 1'b0; supply_in = 4'd0; coin = 1'b0; coin_value = 4'd0;
        req = 1'b0; qty = 4'd0; cancel = 1'b0;
    endtask

    // Inputs that must be ignored while the machine is busy.
    task automatic drive_junk();
        load       = 1'($urandom_range(0, 1));
        supply_in  = 4'($urandom);
        coin       = 1'b1;
        coin_value = 4'($urandom_range(1, 15));
        req        = 1'($urandom_range(0, 1));
        qty        = 4'($urandom_range(1, 4));
        cancel     = 1'($urandom_range(0, 1));
    endtask

    task automatic insert_coin(input int v);
        coin = 1'b1; coin_value = 4'(v);
        tick();
        clear_inputs();
        if (m_credit + v <= 15) m_credit += v;
    endtask

    // Called in the first cycle after an accepted request; follows the whole purchase.
    task automatic run_purchase(input int q, input int exp_change);
        int s0;
        s0 = m_stock;
        for (int k = 0; k < q; k++) begin
            tests_run++;
            if ({dispense, busy, change_valid} !== 3'b110) begin
                tests_failed++;
                $display("FAIL purchase_pulse k=%0d: dispense/busy/change_valid=%b required 110", k, {dispense, busy, change_valid});
            end
            tests_run++;
            if (supply_out !== 4'(s0 - k)) begin
                tests_failed++;
                $display("FAIL purchase_stock k=%0d: supply_out=%0d required %0d", k, supply_out, s0 - k);
            end
            if (k > 0) begin
                tests_run++;
                if (err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL purchase_err k=%0d: err=%b required 0", k, err);
                end
            end
            drive_junk();
            tick();
        end
        tests_run++;
        if ({dispense, busy, change_valid, err} !== 4'b0110) begin
            tests_failed++;
            $display("FAIL purchase_change_flags: dispense/busy/change_valid/err=%b required 0110", {dispense, busy, change_valid, err});
        end
        tests_run++;
        if (change !== 4'(exp_change)) begin
            tests_failed++;
            $display("FAIL purchase_change: change=%0d required %0d", change, exp_change);
        end
        tests_run++;
        if (supply_out !== 4'(s0 - q) || redLight !== (s0 - q == 0)) begin
            tests_failed++;
            $display("FAIL purchase_final_stock: supply_out=%0d redLight=%b required %0d", supply_out, redLight, s0 - q);
        end
        drive_junk();
        tick();
        clear_inputs();
        tests_run++;
        if ({busy, change_valid, dispense, err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL purchase_idle: busy/change_valid/dispense/err=%b required 0000", {busy, change_valid, dispense, err});
        end
        m_stock  = s0 - q;
        m_credit = 0;
        $display("[TB] purchase qty=%0d stock %0d->%0d change=%0d", q, s0, m_stock, exp_change);
    endtask

    // Called in the cycle after an accepted cancel.
    task automatic run_refund(input int exp_change);
        tests_run++;
        if ({change_valid, busy, dispense} !== 3'b110 || change !== 4'(exp_change)) begin
            tests_failed++;
            $display("FAIL refund: change_valid/busy/dispense=%b change=%0d required 110 change=%0d", {change_valid, busy, dispense}, change, exp_change);
        end
        drive_junk();
        tick();
        clear_inputs();
        tests_run++;
        if ({busy, change_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL refund_idle: busy/change_valid=%b required 00", {busy, change_valid});
        end
        m_credit = 0;
        $display("[TB] refund change=%0d", exp_change);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        tests_run++;
        if ({dispense, change_valid, err, busy, redLight} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_flags: dispense/change_valid/err/busy/redLight=%b required 00001", {dispense, change_valid, err, busy, redLight});
        end
        tests_run++;
        if (change !== 4'd0 || supply_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_values: change=%0d supply_out=%0d required 0 0", change, supply_out);
        end
        rst = 1'b0;
        m_stock = 0;
        m_credit = 0;
        $display("[TB] reset");
    endtask

    task automatic test_restock_buy();
        load = 1'b1; supply_in = 4'd7;
        tick();
        clear_inputs();
        m_stock = 7;
        tests_run++;
        if (supply_out !== 4'd7 || redLight !== 1'b0) begin
            tests_failed++;
            $display("FAIL restock: supply_out=%0d redLight=%b required 7 0", supply_out, redLight);
        end
        insert_coin(5);
        insert_coin(5);
        req = 1'b1; qty = 4'd2;
        tick();
        clear_inputs();
        run_purchase(2, 4);
    endtask

    task automatic test_insufficient();
        insert_coin(5);
        req = 1'b1; qty = 4'd2;
        tick();
        clear_inputs();
        tests_run++;
        if ({err, dispense, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL insufficient_err: err/dispense/busy=%b required 100", {err, dispense, busy});
        end
        tick();
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_single_pulse: err=%b required 0", err);
        end
        $display("[TB] reject qty=2 credit=%0d", m_credit);
        cancel = 1'b1;
        tick();
        clear_inputs();
        run_refund(5);
    endtask

    task automatic test_stock_boundary();
        load = 1'b1; supply_in = 4'd2;
        tick();
        clear_inputs();
        m_stock = 2;
        insert_coin(5);
        insert_coin(5);
        insert_coin(5);
        req = 1'b1; qty = 4'd3;
        tick();
        clear_inputs();
        tests_run++;
        if ({err, dispense} !== 2'b10) begin
            tests_failed++;
            $display("FAIL stock_reject: err/dispense=%b required 10", {err, dispense});
        end
        $display("[TB] reject qty=3 stock=2");
        req = 1'b1; qty = 4'd2;
        tick();
        clear_inputs();
        run_purchase(2, 9);
    endtask

    task automatic test_saturation();
        insert_coin(5);
        insert_coin(5);
        insert_coin(2);
        coin = 1'b1; coin_value = 4'd5;
        tick();
        clear_inputs();
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_err: err=%b required 1", err);
        end
        coin = 1'b1; coin_value = 4'd3;
        tick();
        clear_inputs();
        m_credit = 15;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_to_15: err=%b required 0", err);
        end
        $display("[TB] coin saturation credit=15");
        cancel = 1'b1;
        tick();
        clear_inputs();
        run_refund(15);
    endtask

    task automatic test_busy_simultaneous();
        // Coins dropped during DISPENSE/CHANGE must not reach the change.
        load = 1'b1; supply_in = 4'd3;
        tick();
        clear_inputs();
        m_stock = 3;
        insert_coin(3);
        insert_coin(3);
        req = 1'b1; qty = 4'd2;
        tick();
        clear_inputs();
        run_purchase(2, 0);

        insert_coin(3);
        load = 1'b1; supply_in = 4'd4; req = 1'b1; qty = 4'd1;
        tick();
        clear_inputs();
        m_stock = 4;
        tests_run++;
        if ({dispense, err, busy} !== 3'b000 || supply_out !== 4'd4) begin
            tests_failed++;
            $display("FAIL load_with_req: dispense/err/busy=%b supply_out=%0d required 000 4", {dispense, err, busy}, supply_out);
        end
        $display("[TB] load+req stock=4");

        cancel = 1'b1; req = 1'b1; qty = 4'd1;
        tick();
        clear_inputs();
        run_refund(3);
        tests_run++;
        if (supply_out !== 4'd4) begin
            tests_failed++;
            $display("FAIL cancel_with_req_stock: supply_out=%0d required 4", supply_out);
        end
    endtask

    task automatic test_random();
        int ld, cn, cv, rq, q, cc, sin;
        int exp_err, new_stock, new_credit, action;
        for (int it = 0; it < 300; it++) begin
            ld  = ($urandom_range(0, 3) == 0);
            sin = $urandom_range(0, 15);
            cn  = $urandom_range(0, 1);
            cv  = $urandom_range(1, 8);
            rq  = ($urandom_range(0, 2) == 0);
            q   = $urandom_range(0, 5);
            cc  = ($urandom_range(0, 7) == 0);
            load = 1'(ld); supply_in = 4'(sin); coin = 1'(cn); coin_value = 4'(cv);
            req = 1'(rq); qty = 4'(q); cancel = 1'(cc);

            exp_err    = 0;
            new_stock  = ld ? sin : m_stock;
            new_credit = m_credit;
            action     = 0;
            if (cn) begin
                if (m_credit + cv <= 15) new_credit = m_credit + cv;
                else exp_err = 1;
            end
            if (cc) begin
                if (m_credit > 0) action = 2;
            end else if (rq && !ld) begin
                if (q == 0 || q > m_stock || q * PRICE > m_credit) exp_err = 1;
                else action = 1;
            end

            tick();
            clear_inputs();
            tests_run++;
            if (err !== 1'(exp_err)) begin
                tests_failed++;
                $display("FAIL rand_err it=%0d: err=%b required %0d", it, err, exp_err);
            end
            if (action == 1) begin
                m_credit = new_credit;
                run_purchase(q, new_credit - q * PRICE);
            end else if (action == 2) begin
                m_stock = new_stock;
                run_refund(new_credit);
            end else begin
                tests_run++;
                if ({dispense, change_valid, busy} !== 3'b000 || supply_out !== 4'(new_stock) || redLight !== (new_stock == 0)) begin
                    tests_failed++;
                    $display("FAIL rand_idle it=%0d: dispense/change_valid/busy=%b supply_out=%0d required 000 %0d", it, {dispense, change_valid, busy}, supply_out, new_stock);
                end
                m_stock  = new_stock;
                m_credit = new_credit;
                $display("[TB] idle it=%0d stock=%0d credit=%0d err=%0d", it, m_stock, m_credit, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid_purchase();
        load = 1'b1; supply_in = 4'd5;
        tick();
        clear_inputs();
        m_stock = 5;
        while (m_credit < 12) insert_coin(1);
        req = 1'b1; qty = 4'd4;
        tick();
        clear_inputs();
        tests_run++;
        if (dispense !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_first_pulse: dispense=%b required 1", dispense);
        end
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if ({dispense, change_valid, err, busy, redLight} !== 5'b00001 || supply_out !== 4'd0 || change !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: dispense/change_valid/err/busy/redLight=%b supply_out=%0d change=%0d required 00001 0 0",
                     {dispense, change_valid, err, busy, redLight}, supply_out, change);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({change_valid, dispense, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset_after: change_valid/dispense/busy=%b required 000", {change_valid, dispense, busy});
        end
        m_stock = 0;
        m_credit = 0;
        $display("[TB] reset during purchase qty=4");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_restock_buy();
        test_insufficient();
        test_stock_boundary();
        test_saturation();
        test_busy_simultaneous();
        test_random();
        test_reset_mid_purchase();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
